fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter in front of a shared synchronous FIFO. One
//   requester at a time owns the FIFO write port for a burst of up to
//   MAX_BURST beats. Ownership ends when the burst completes or when the
//   owner drops its valid. Picking the next owner costs one idle cycle.
//
// Parameters
//   DATA_WIDTH : width of one data beat
//   NUM_REQ    : number of requesters (2..16)
//   MAX_BURST  : maximum beats per grant (1..255)
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   req_valid    : per-requester valid
//   req_data     : per-requester data, element i belongs to requester i
//   req_ready    : per-requester accept
//   fifo_full    : full flag from the shared FIFO
//   fifo_wr_en   : FIFO write enable
//   fifo_data_in : FIFO write data, zero when no requester owns the FIFO
//   grant_id     : current owner, or the last owner while idle
//   busy         : high while a requester owns the FIFO
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic                                 fifo_full,
    output logic                                 fifo_wr_en,
    output logic [DATA_WIDTH-1:0]                fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]           grant_id,
    output logic                                 busy
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } state_e;

    state_e         state;
    logic [7:0]     beat_cnt;
    logic [IdW-1:0] owner;
    logic [IdW-1:0] last_grant;

    logic           in_lock;
    logic           owner_valid;
    logic           beat;
    logic           burst_done;

    logic [IdW-1:0] pick;
    logic           pick_valid;
    logic [IdW-1:0] pick_hi;
    logic           pick_hi_found;
    logic [IdW-1:0] pick_lo;
    logic           pick_lo_found;

    // Round-robin search starting just above last_grant. Requesters above
    // last_grant win over those at or below it, which gives the wrap.
    always_comb begin
        pick_hi       = '0;
        pick_hi_found = 1'b0;
        pick_lo       = '0;
        pick_lo_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (IdW'(i) > last_grant) begin
                    if (!pick_hi_found) begin
                        pick_hi       = IdW'(i);
                        pick_hi_found = 1'b1;
                    end
                end else if (!pick_lo_found) begin
                    pick_lo       = IdW'(i);
                    pick_lo_found = 1'b1;
                end
            end
        end
        pick       = pick_hi_found ? pick_hi : pick_lo;
        pick_valid = pick_hi_found | pick_lo_found;
    end

    // Outputs are forced to zero while reset is high, even mid-burst, so
    // the FIFO never sees a write during the reset cycle.
    assign in_lock     = (state == StLock) && !reset;
    assign owner_valid = req_valid[owner];
    assign beat        = in_lock && owner_valid && !fifo_full;
    assign burst_done  = (beat_cnt + 8'd1) == 8'(MAX_BURST);

    always_comb begin
        req_ready    = '0;
        fifo_data_in = '0;
        if (in_lock) begin
            req_ready[owner] = !fifo_full;
            fifo_data_in     = req_data[owner];
        end
    end

    assign fifo_wr_en = beat;
    assign busy       = in_lock;
    assign grant_id   = reset ? '0 : owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            beat_cnt   <= 8'd0;
            owner      <= '0;
            // Start with the top requester as last winner so requester 0 wins first.
            last_grant <= IdW'(NUM_REQ - 1);
        end else begin
            case (state)
                StIdle: begin
                    if (pick_valid) begin
                        owner    <= pick;
                        beat_cnt <= 8'd0;
                        state    <= StLock;
                    end
                end
                StLock: begin
                    if (!owner_valid) begin
                        // Owner gave up: release without a beat.
                        state      <= StIdle;
                        last_grant <= owner;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (burst_done) begin
                            state      <= StIdle;
                            last_grant <= owner;
                        end
                    end
                    // Full FIFO with valid owner: hold, no timeout.
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. Instance a uses MAX_BURST=4, instance
// b uses MAX_BURST=1. Inputs change 1 time unit after the rising edge and
// outputs are checked 2 units after it.
module tb_fifo_wr_arbiter;

    logic            clk = 1'b0;
    logic            reset;
    logic            full;

    logic [3:0]      a_valid;
    logic [3:0][7:0] a_data;
    logic [3:0]      a_ready;
    logic            a_wr;
    logic [7:0]      a_dout;
    logic [1:0]      a_gid;
    logic            a_busy;

    logic [3:0]      b_valid;
    logic [3:0][7:0] b_data;
    logic [3:0]      b_ready;
    logic            b_wr;
    logic [7:0]      b_dout;
    logic [1:0]      b_gid;
    logic            b_busy;

    int n_vec   = 0;
    int n_err   = 0;
    int a_writes = 0;
    int w0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_wr) a_writes <= a_writes + 1;
    end

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (a_valid),
        .req_data     (a_data),
        .req_ready    (a_ready),
        .fifo_full    (full),
        .fifo_wr_en   (a_wr),
        .fifo_data_in (a_dout),
        .grant_id     (a_gid),
        .busy         (a_busy)
    );

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (1)
    ) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (b_valid),
        .req_data     (b_data),
        .req_ready    (b_ready),
        .fifo_full    (1'b0),
        .fifo_wr_en   (b_wr),
        .fifo_data_in (b_dout),
        .grant_id     (b_gid),
        .busy         (b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] g;
        logic [7:0] exp_data;

        reset   = 1'b1;
        full    = 1'b0;
        a_valid = 4'h0;
        b_valid = 4'h0;
        a_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        b_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset state
        repeat (2) cyc();
        #1;
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_gid", a_gid, 0);
        check_eq("rst_ready", a_ready, 0);
        check_eq("rst_wr", a_wr, 0);
        check_eq("rst_dout", a_dout, 0);
        a_valid = 4'hF;
        #1;
        check_eq("rst_ready_v", a_ready, 0);
        check_eq("rst_wr_v", a_wr, 0);

        // All four requesting: grants 0,1,2,3,0, four beats each, one idle between
        cyc();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            g = 2'(k % 4);
            check_eq("arb_busy", a_busy, 0);
            check_eq("arb_ready", a_ready, 0);
            check_eq("arb_wr", a_wr, 0);
            check_eq("arb_dout", a_dout, 0);
            if (k > 0) check_eq("arb_gid_prev", a_gid, 32'((k - 1) % 4));
            for (int b = 0; b < 4; b++) begin
                cyc();
                #1;
                check_eq("rr_gid", a_gid, 32'(g));
                check_eq("rr_busy", a_busy, 1);
                check_eq("rr_wr", a_wr, 1);
                check_eq("rr_ready", a_ready, 32'(4'b0001 << g));
                check_eq("rr_dout", a_dout, 32'(8'h11 * (32'(g) + 1)));
            end
            cyc();
            #1;
        end

        // Requester 2 alone, two beats then drops valid
        a_valid = 4'b0100;
        #1;
        check_eq("r2_idle_busy", a_busy, 0);
        check_eq("r2_idle_gid", a_gid, 0);
        w0 = a_writes;
        cyc();
        #1;
        check_eq("r2_b1_gid", a_gid, 2);
        check_eq("r2_b1_wr", a_wr, 1);
        check_eq("r2_b1_dout", a_dout, 32'h33);
        cyc();
        #1;
        check_eq("r2_b2_wr", a_wr, 1);
        cyc();
        a_valid = 4'b0000;
        #1;
        check_eq("r2_drop_busy", a_busy, 1);
        check_eq("r2_drop_wr", a_wr, 0);
        check_eq("r2_drop_ready", a_ready, 32'b0100);
        cyc();
        #1;
        check_eq("r2_rel_busy", a_busy, 0);
        check_eq("r2_rel_gid", a_gid, 2);
        check_eq("r2_writes", 32'(a_writes - w0), 2);

        // last_grant=2 so all-valid must pick 3 next; reset hits during its beat 2
        a_valid = 4'hF;
        cyc();
        #1;
        check_eq("lg_gid", a_gid, 3);
        check_eq("r3_b1_wr", a_wr, 1);
        check_eq("r3_b1_dout", a_dout, 32'h44);
        cyc();
        #1;
        check_eq("r3_b2_wr", a_wr, 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", a_busy, 0);
        check_eq("mid_rst_ready", a_ready, 0);
        check_eq("mid_rst_wr", a_wr, 0);
        check_eq("mid_rst_gid", a_gid, 0);
        cyc();
        reset   = 1'b0;
        a_valid = 4'b1001;
        #1;
        check_eq("post_rst_busy", a_busy, 0);
        check_eq("post_rst_ready", a_ready, 0);
        cyc();
        #1;
        check_eq("post_rst_gid", a_gid, 0);
        check_eq("post_rst_lock", a_busy, 1);

        // Owner 0 drops; then requester 1 runs a burst with a 5-cycle full stall
        a_valid = 4'b0010;
        #1;
        check_eq("r0_drop_wr", a_wr, 0);
        check_eq("r0_drop_ready", a_ready, 32'b0001);
        cyc();
        #1;
        check_eq("r1_idle_busy", a_busy, 0);
        w0 = a_writes;
        for (int b = 0; b < 2; b++) begin
            cyc();
            #1;
            check_eq("r1_pre_gid", a_gid, 1);
            check_eq("r1_pre_wr", a_wr, 1);
        end
        for (int s = 0; s < 5; s++) begin
            cyc();
            full = 1'b1;
            #1;
            check_eq("full_wr", a_wr, 0);
            check_eq("full_ready", a_ready, 0);
            check_eq("full_busy", a_busy, 1);
            check_eq("full_gid", a_gid, 1);
        end
        cyc();
        full = 1'b0;
        #1;
        check_eq("r1_b3_wr", a_wr, 1);
        check_eq("r1_b3_dout", a_dout, 32'h22);
        check_eq("r1_b3_ready", a_ready, 32'b0010);
        cyc();
        #1;
        check_eq("r1_b4_wr", a_wr, 1);
        cyc();
        a_valid = 4'b0000;
        #1;
        check_eq("r1_rel_busy", a_busy, 0);
        check_eq("r1_writes", 32'(a_writes - w0), 4);

        // MAX_BURST=1 instance: 0,2,0,2 one beat each
        b_valid = 4'b0101;
        #1;
        check_eq("b_idle_busy", b_busy, 0);
        for (int k = 0; k < 4; k++) begin
            g        = (k % 2 == 1) ? 2'd2 : 2'd0;
            exp_data = (k % 2 == 1) ? 8'hC2 : 8'hA0;
            cyc();
            #1;
            check_eq("b_gid", b_gid, 32'(g));
            check_eq("b_wr", b_wr, 1);
            check_eq("b_dout", b_dout, 32'(exp_data));
            check_eq("b_ready", b_ready, 32'(4'b0001 << g));
            cyc();
            #1;
            check_eq("b_gap_busy", b_busy, 0);
            check_eq("b_gap_wr", b_wr, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
